// File: rtl/ks4_chunk_add_seq.sv
// Multi-cycle WIDTH-bit adder: one 4-bit Kogge-Stone pass per clock, LS chunk first.
// Define KS_SEQ_OVF_EN to add the registered signed-overflow output ovf.

module kogge_stone_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] g0, p0, g1, p1, g2, p2;
    logic [4:0] c;

    // Two-level parallel-prefix carry tree (span 1, then span 2), carry-in folded in last.
    always_comb begin
        g0    = a_i & b_i;
        p0    = a_i ^ b_i;
        g1[0] = g0[0];
        p1[0] = p0[0];
        for (int i = 1; i < 4; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end
        g2[1:0] = g1[1:0];
        p2[1:0] = p1[1:0];
        for (int i = 2; i < 4; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
        c[0] = cin_i;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g2[i] | (p2[i] & cin_i);
        end
        sum_o  = p0 ^ c[3:0];
        cout_o = c[4];
    end
endmodule

module ks4_chunk_add_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef KS_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned CHUNKS = WIDTH / 4;
    localparam int unsigned IDX_W  = $clog2(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef KS_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [IDX_W+1:0] bit_base;
    logic [3:0]       ks_a, ks_b, ks_sum;
    logic             ks_cout;
    logic [WIDTH-1:0] acc_upd;

    assign bit_base = {idx_q, 2'b00};
    assign ks_a     = op_a_q[bit_base +: 4];
    assign ks_b     = op_b_q[bit_base +: 4];

    kogge_stone_4 u_ks (
        .a_i    (ks_a),
        .b_i    (ks_b),
        .cin_i  (carry_q),
        .sum_o  (ks_sum),
        .cout_o (ks_cout)
    );

    // Accumulator with the current chunk merged in; on the last pass this is the full sum.
    always_comb begin
        acc_upd                = acc_q;
        acc_upd[bit_base +: 4] = ks_sum;
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef KS_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    op_a_d  = in1;
                    op_b_d  = in2;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                acc_d   = acc_upd;
                carry_d = ks_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    sum_d   = acc_upd;
                    cout_d  = ks_cout;
`ifdef KS_SEQ_OVF_EN
                    ovf_d   = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ ks_sum[3] ^ ks_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KS_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef KS_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef KS_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_ks4_chunk_add_seq.sv
// Bench for ks4_chunk_add_seq (WIDTH=16): directed literal cases plus random traffic
// against a cycle-count/arithmetic reference model. Honours KS_SEQ_OVF_EN.

module tb_ks4_chunk_add_seq;
    localparam int unsigned W      = 16;
    localparam int unsigned CHUNKS = W / 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in1   = '0;
    logic [W-1:0] in2   = '0;
    logic         cin   = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef KS_SEQ_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    ks4_chunk_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef KS_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an add takes CHUNKS edges after acceptance; result is plain arithmetic.
    int           m_rem  = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout, p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_sum  = p_sum;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                int          s_signed;
                logic [W:0]  full;
                full     = {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, cin};
                p_sum    = full[W-1:0];
                p_cout   = full[W];
                s_signed = int'($signed(in1)) + int'($signed(in2)) + int'(cin);
                p_ovf    = (s_signed > 32767) || (s_signed < -32768);
                m_rem    = CHUNKS;
            end
        end
    end

    int ndone = 0;
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("sum",  32'(sum),  32'(m_sum));
        chk("cout", 32'(cout), 32'(m_cout));
`ifdef KS_SEQ_OVF_EN
        chk("ovf",  32'(ovf),  32'(m_ovf));
`endif
        if (done) ndone++;
    end

    // Called #1 after an edge while the DUT is IDLE or DONE; returns #1 after the done edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input string nm);
        start = 1'b1; in1 = a; in2 = b; cin = c;
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom; cin = 1'($urandom);
        chk({nm, "_busy1"}, 32'(busy), 32'd1);
        repeat (CHUNKS - 1) @(posedge clk);
        #1;
        chk({nm, "_early_done"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
        chk({nm, "_sum"},  32'(sum),  32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, "one");
        @(posedge clk); #1;
        chk("one_pulse", 32'(done), 32'd0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
`ifdef KS_SEQ_OVF_EN
        chk("ripple_ovf", 32'(ovf), 32'd0);
`endif
        run_op(16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, "abcd");
        run_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, "b2b");
`ifdef KS_SEQ_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovf");
        chk("ovf_flag", 32'(ovf), 32'd1);
`endif
        @(posedge clk); #1;

        // Start during RUN must be ignored.
        n0 = ndone;
        start = 1'b1; in1 = 16'h1111; in2 = 16'h2222; cin = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; in1 = 16'hFFFF; in2 = 16'hFFFF;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ign_ndone", 32'(ndone - n0), 32'd1);
        chk("ign_sum",   32'(sum),  32'h3333);
        chk("ign_cout",  32'(cout), 32'd0);

        // Async reset mid-operation.
        n0 = ndone;
        start = 1'b1; in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_ndone", 32'(ndone - n0), 32'd0);
        @(posedge clk); #1;
        run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "post_rst");

        // Random traffic, including starts during RUN and in DONE.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            in1   = $urandom;
            in2   = $urandom;
            cin   = 1'($urandom);
            if ((i % 8) == 0) begin
                in1 = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h7FFF;
                in2 = 16'($urandom_range(0, 2));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (CHUNKS + 2) @(posedge clk);
        #1;
        chk("rand_saw_done", 32'(ndone > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
